// File: rtl/sobel_edge_param_if.sv
// Greyscale pixel stream in, edge map and gradient magnitude out, grouped as one bundle.
// The testbench/upstream side drives pre_* (master); the detector drives post_* (slave).
interface sobel_edge_param_if #(
    parameter int DW = 8
);
    logic          pre_img_vsync;
    logic          pre_img_hsync;
    logic          pre_img_valid;
    logic [DW-1:0] pre_img_data;
    logic          post_img_vsync;
    logic          post_img_hsync;
    logic          post_img_valid;
    logic          post_img_edge;
    logic [DW-1:0] post_img_mag;

    modport master (
        output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        input  post_img_vsync, post_img_hsync, post_img_valid, post_img_edge, post_img_mag
    );

    modport slave (
        input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        output post_img_vsync, post_img_hsync, post_img_valid, post_img_edge, post_img_mag
    );
endinterface

// File: rtl/sobel_edge_param.sv
// Parametrised Sobel edge detector: internal 3x3 window from two line buffers,
// run-time L1 / max magnitude select, saturated magnitude and thresholded edge out.
module sobel_edge_param #(
    parameter int DW          = 8,
    parameter int IMG_W       = 640,
    parameter bit BORDER_EDGE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW+2:0] thresh,
    input  logic          mag_mode,
    sobel_edge_param_if.slave img
);
    localparam int LAT = 5;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    logic                 r_vs_prev;
    logic [CW-1:0]        r_col;
    logic [1:0]           r_row;
    logic [DW-1:0]        r_ram_a [IMG_W];
    logic [DW-1:0]        r_ram_b [IMG_W];
    logic [DW-1:0]        r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
    logic [DW+1:0]        r_sxr, r_sxl, r_syb, r_syt;
    logic signed [DW+2:0] r_gx, r_gy;
    logic [DW+1:0]        r_ax, r_ay;
    logic [DW+2:0]        r_mag;
    logic [LAT-1:0]       r_vld, r_bdr, r_vs, r_hs;
    logic                 r_o_vs, r_o_hs, r_o_vld, r_o_edge;
    logic [DW-1:0]        r_o_mag;

    logic                 w_vs_rise;
    logic [CW-1:0]        w_col;
    logic [1:0]           w_row;
    logic                 w_border;
    logic [DW-1:0]        w_a, w_b;
    logic signed [DW+2:0] w_gx_neg, w_gy_neg;
    logic [DW+2:0]        w_mag_sum, w_mag_max;
    logic [DW-1:0]        w_mag_sat;

    // A vsync rise forces the current beat to (0,0) in the same clock.
    always_comb begin
        w_vs_rise = img.pre_img_vsync & ~r_vs_prev;
        w_col     = w_vs_rise ? '0 : r_col;
        w_row     = w_vs_rise ? '0 : r_row;
        w_border  = (w_row < 2'd2) || (w_col < CW'(2));
        w_a       = r_ram_a[w_col];
        w_b       = r_ram_b[w_col];
    end

    // Row only matters as "below 2", so it saturates at 2 instead of counting the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_vs_prev <= img.pre_img_vsync;
            if (img.pre_img_valid) begin
                r_col <= (w_col == COL_LAST) ? '0 : w_col + CW'(1);
                r_row <= ((w_col == COL_LAST) && (w_row != 2'd2)) ? w_row + 2'd1 : w_row;
            end else if (w_vs_rise) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (img.pre_img_valid) begin
            r_ram_a[w_col] <= img.pre_img_data;
            r_ram_b[w_col] <= w_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33} <= '0;
        end else if (img.pre_img_valid) begin
            r_p11 <= r_p12;  r_p12 <= r_p13;  r_p13 <= w_b;
            r_p21 <= r_p22;  r_p22 <= r_p23;  r_p23 <= w_a;
            r_p31 <= r_p32;  r_p32 <= r_p33;  r_p33 <= img.pre_img_data;
        end
    end

    always_comb begin
        w_gx_neg  = -r_gx;
        w_gy_neg  = -r_gy;
        w_mag_sum = {1'b0, r_ax} + {1'b0, r_ay};
        w_mag_max = (r_ax > r_ay) ? {1'b0, r_ax} : {1'b0, r_ay};
        w_mag_sat = (r_mag > {3'b000, {DW{1'b1}}}) ? '1 : r_mag[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_sxr, r_sxl, r_syb, r_syt} <= '0;
            r_gx  <= '0;
            r_gy  <= '0;
            r_ax  <= '0;
            r_ay  <= '0;
            r_mag <= '0;
        end else begin
            r_sxr <= {2'b00, r_p13} + {1'b0, r_p23, 1'b0} + {2'b00, r_p33};
            r_sxl <= {2'b00, r_p11} + {1'b0, r_p21, 1'b0} + {2'b00, r_p31};
            r_syb <= {2'b00, r_p31} + {1'b0, r_p32, 1'b0} + {2'b00, r_p33};
            r_syt <= {2'b00, r_p11} + {1'b0, r_p12, 1'b0} + {2'b00, r_p13};
            r_gx  <= $signed({1'b0, r_sxr}) - $signed({1'b0, r_sxl});
            r_gy  <= $signed({1'b0, r_syb}) - $signed({1'b0, r_syt});
            r_ax  <= r_gx[DW+2] ? w_gx_neg[DW+1:0] : r_gx[DW+1:0];
            r_ay  <= r_gy[DW+2] ? w_gy_neg[DW+1:0] : r_gy[DW+1:0];
            r_mag <= mag_mode ? w_mag_max : w_mag_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_bdr    <= '0;
            r_vs     <= '0;
            r_hs     <= '0;
            r_o_vs   <= 1'b0;
            r_o_hs   <= 1'b0;
            r_o_vld  <= 1'b0;
            r_o_edge <= 1'b0;
            r_o_mag  <= '0;
        end else begin
            r_vld    <= {r_vld[LAT-2:0], img.pre_img_valid};
            r_bdr    <= {r_bdr[LAT-2:0], w_border};
            r_vs     <= {r_vs[LAT-2:0], img.pre_img_vsync};
            r_hs     <= {r_hs[LAT-2:0], img.pre_img_hsync};
            r_o_vs   <= r_vs[LAT-1];
            r_o_hs   <= r_hs[LAT-1];
            r_o_vld  <= r_vld[LAT-1];
            r_o_edge <= r_vld[LAT-1] & (r_bdr[LAT-1] ? BORDER_EDGE : (r_mag > thresh));
            r_o_mag  <= (r_vld[LAT-1] && !r_bdr[LAT-1]) ? w_mag_sat : '0;
        end
    end

    assign img.post_img_vsync = r_o_vs;
    assign img.post_img_hsync = r_o_hs;
    assign img.post_img_valid = r_o_vld;
    assign img.post_img_edge  = r_o_edge;
    assign img.post_img_mag   = r_o_mag;
endmodule

// File: tb/tb_sobel_edge_param.sv
// Scoreboard bench for sobel_edge_param: two instances (BORDER_EDGE 1 and 0) share one
// stimulus stream; a golden Sobel model queues expected beats, a monitor pops and compares.
module tb_sobel_edge_param;
    localparam int DW = 8;
    localparam int W  = 16;

    typedef struct {
        int         stamp;
        logic       edge_b;
        logic [7:0] mag;
        logic       border;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] thresh;
    logic        mag_mode;

    sobel_edge_param_if #(.DW(DW)) if_a ();
    sobel_edge_param_if #(.DW(DW)) if_b ();

    assign if_b.pre_img_vsync = if_a.pre_img_vsync;
    assign if_b.pre_img_hsync = if_a.pre_img_hsync;
    assign if_b.pre_img_valid = if_a.pre_img_valid;
    assign if_b.pre_img_data  = if_a.pre_img_data;

    sobel_edge_param #(.DW(DW), .IMG_W(W), .BORDER_EDGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .thresh(thresh), .mag_mode(mag_mode), .img(if_a));
    sobel_edge_param #(.DW(DW), .IMG_W(W), .BORDER_EDGE(1'b0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .thresh(thresh), .mag_mode(mag_mode), .img(if_b));

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     n_in   = 0;
    int     n_out  = 0;
    bit [1:0] hist [64];
    exp_t   sb [$];
    exp_t   mon_e;
    int     pix [16][16];
    int     m_r = 0, m_c = 0;
    logic   m_prev_vs = 1'b0;

    // posedge count and the sync values each posedge loads into the delay line
    always @(posedge clk) begin
        cyc = cyc + 1;
        hist[cyc & 63] = rst_n ? {if_a.pre_img_vsync, if_a.pre_img_hsync} : 2'b00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({if_a.post_img_vsync, if_a.post_img_hsync, if_a.post_img_valid, if_a.post_img_edge,
                 if_a.post_img_mag, if_b.post_img_valid, if_b.post_img_edge, if_b.post_img_mag} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got vld=%b edge=%b mag=%0d want all 0",
                         if_a.post_img_valid, if_a.post_img_edge, if_a.post_img_mag);
            end
        end else begin
            checks++;
            if ({if_a.post_img_vsync, if_a.post_img_hsync} !== hist[(cyc - 5) & 63]) begin
                errors++;
                $display("FAIL sync_delay cyc=%0d got %b want %b", cyc,
                         {if_a.post_img_vsync, if_a.post_img_hsync}, hist[(cyc - 5) & 63]);
            end
            checks++;
            if (if_b.post_img_valid !== if_a.post_img_valid) begin
                errors++;
                $display("FAIL valid_b0 got %b want %b", if_b.post_img_valid, if_a.post_img_valid);
            end
            if (if_a.post_img_valid === 1'b1) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d got valid want none pending", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc - mon_e.stamp != 5) begin
                        errors++;
                        $display("FAIL latency got %0d want 5", cyc - mon_e.stamp);
                    end
                    checks++;
                    if ({if_a.post_img_edge, if_a.post_img_mag} !== {mon_e.edge_b, mon_e.mag}) begin
                        errors++;
                        $display("FAIL pixel_a cyc=%0d got edge=%b mag=%0d want edge=%b mag=%0d",
                                 cyc, if_a.post_img_edge, if_a.post_img_mag, mon_e.edge_b, mon_e.mag);
                    end
                    checks++;
                    if ({if_b.post_img_edge, if_b.post_img_mag} !==
                        {mon_e.border ? 1'b0 : mon_e.edge_b, mon_e.mag}) begin
                        errors++;
                        $display("FAIL pixel_b0 cyc=%0d got edge=%b mag=%0d want edge=%b mag=%0d",
                                 cyc, if_b.post_img_edge, if_b.post_img_mag,
                                 mon_e.border ? 1'b0 : mon_e.edge_b, mon_e.mag);
                    end
                end
            end else begin
                checks++;
                if ({if_a.post_img_edge, if_a.post_img_mag, if_b.post_img_edge, if_b.post_img_mag} !== '0) begin
                    errors++;
                    $display("FAIL idle_zero got edge=%b mag=%0d want 0 0",
                             if_a.post_img_edge, if_a.post_img_mag);
                end
            end
        end
    end

    function automatic int pat(int id, int r, int c);
        case (id)
            0:       return 100;
            1:       return (c < 8) ? 0 : 200;
            2:       return 10 * (r + c);
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic exp_t model(int r, int c);
        exp_t e;
        int gx, gy, ax, ay, m;
        e.stamp  = cyc + 1;
        e.border = (r < 2) || (c < 2);
        if (e.border) begin
            e.edge_b = 1'b1;
            e.mag    = 8'd0;
        end else begin
            gx = (pix[r-2][c] + 2 * pix[r-1][c] + pix[r][c])
               - (pix[r-2][c-2] + 2 * pix[r-1][c-2] + pix[r][c-2]);
            gy = (pix[r][c-2] + 2 * pix[r][c-1] + pix[r][c])
               - (pix[r-2][c-2] + 2 * pix[r-2][c-1] + pix[r-2][c]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            m  = mag_mode ? ((ax > ay) ? ax : ay) : ax + ay;
            e.edge_b = (m > int'(thresh));
            e.mag    = 8'((m > 255) ? 255 : m);
        end
        return e;
    endfunction

    task automatic drive_cycle(input logic vs, input logic hs, input logic v, input int d);
        @(negedge clk);
        if_a.pre_img_vsync = vs;
        if_a.pre_img_hsync = hs;
        if_a.pre_img_valid = v;
        if_a.pre_img_data  = 8'(d);
        if (rst_n) begin
            if (vs && !m_prev_vs) begin
                m_r = 0;
                m_c = 0;
            end
            m_prev_vs = vs;
            if (v) begin
                pix[m_r][m_c] = d;
                sb.push_back(model(m_r, m_c));
                n_in++;
                if (m_c == W - 1) begin
                    m_c = 0;
                    if (m_r < 15) m_r++;
                end else begin
                    m_c++;
                end
            end
        end
    endtask

    task automatic drain();
        repeat (10) drive_cycle(1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_pending got %0d beats outstanding want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (n_out != n_in) begin
            errors++;
            $display("FAIL beat_count got %0d outputs want %0d", n_out, n_in);
            n_in = n_out;
        end
    endtask

    task automatic run_frame(input int id, input int rows, input bit gaps, input bit vs_on_first);
        if (!vs_on_first) repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 0);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) drive_cycle(1'b1, 1'b1, 1'b0, 0);
                drive_cycle(1'b1, 1'b1, 1'b1, pat(id, r, c));
            end
            repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 0);
        end
        drain();
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        if_a.pre_img_vsync = 1'b0;
        if_a.pre_img_hsync = 1'b0;
        if_a.pre_img_valid = 1'b0;
        if_a.pre_img_data  = '0;
        sb.delete();
        n_in = n_out;
        m_prev_vs = 1'b0;
        m_r = 0;
        m_c = 0;
        for (int i = 0; i < 64; i++) hist[i] = 2'b00;
        #1;
        checks++;
        if ({if_a.post_img_vsync, if_a.post_img_hsync, if_a.post_img_valid, if_a.post_img_edge,
             if_a.post_img_mag} !== '0) begin
            errors++;
            $display("FAIL reset_immediate got vld=%b edge=%b mag=%0d want all 0",
                     if_a.post_img_valid, if_a.post_img_edge, if_a.post_img_mag);
        end
        repeat (n) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        thresh   = 11'd50;
        mag_mode = 1'b0;
        if_a.pre_img_vsync = 1'b0;
        if_a.pre_img_hsync = 1'b0;
        if_a.pre_img_valid = 1'b0;
        if_a.pre_img_data  = '0;
        repeat (3) @(negedge clk);
        apply_reset(3);
    endtask

    task automatic test_uniform();
        thresh = 11'd50;  mag_mode = 1'b0;
        run_frame(0, 8, 1'b0, 1'b0);
    endtask

    task automatic test_vstep();
        thresh = 11'd100; mag_mode = 1'b0;
        run_frame(1, 8, 1'b1, 1'b0);
    endtask

    task automatic test_ramp();
        thresh = 11'd100; mag_mode = 1'b0;
        run_frame(2, 8, 1'b0, 1'b0);
        mag_mode = 1'b1;
        run_frame(2, 8, 1'b1, 1'b1);
    endtask

    task automatic test_vsync_restart();
        thresh = 11'd80;  mag_mode = 1'b0;
        drive_cycle(1'b1, 1'b0, 1'b0, 0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) drive_cycle(1'b1, 1'b1, 1'b1, pat(3, r, c));
        for (int c = 0; c < 5; c++) drive_cycle(1'b1, 1'b1, 1'b1, pat(3, 2, c));
        drive_cycle(1'b0, 1'b0, 1'b0, 0);
        run_frame(3, 6, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        thresh = 11'd60;  mag_mode = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2 * W + 4; i++) drive_cycle(1'b1, 1'b1, 1'b1, pat(3, 0, 0));
        apply_reset(3);
        run_frame(3, 6, 1'b0, 1'b0);
    endtask

    task automatic test_thresh_max();
        thresh = '1;      mag_mode = 1'b0;
        run_frame(1, 6, 1'b1, 1'b0);
        mag_mode = 1'b1;
        run_frame(3, 5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_vstep();
        test_ramp();
        test_vsync_restart();
        test_reset_mid();
        test_thresh_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
